// File: rtl/rv32i_types.sv
// Shared RV32I rename types: index widths, arch/phys register index types
// and the ROB-to-RRF commit record.
package rv32i_types;

    localparam int NUM_ARCH_REGS  = 32;
    localparam int NUM_PREGS      = 64;
    localparam int ARCH_IDX_WIDTH = $clog2(NUM_ARCH_REGS);
    localparam int PREG_IDX_WIDTH = $clog2(NUM_PREGS);

    typedef logic [ARCH_IDX_WIDTH-1:0] arch_idx_t;
    typedef logic [PREG_IDX_WIDTH-1:0] preg_idx_t;

    typedef struct packed {
        arch_idx_t rd;
        preg_idx_t pd;
    } rrf_commit_t;

    function automatic preg_idx_t identity_preg(input int idx);
        return preg_idx_t'(idx);
    endfunction

endpackage

// File: rtl/retire_rename_table_free_preg_queue.sv
// Small FIFO of retired physical registers waiting to be handed back to the
// free list. Pointers carry an extra wrap bit to tell full from empty.
module free_preg_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  preg_idx_t push_data_i,
    input  logic      pop_i,
    output preg_idx_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    preg_idx_t   mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};

    assign head_o = mem_q[rd_ptr_q[AW-1:0]];

    // Storage is cleared on reset so the head reads as preg 0 while idle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (do_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/retire_rename_table.sv
// Retirement rename table: committed arch-to-phys map, retires superseded
// pregs to the free list. Optional duplicate-mapping check: RRF_DUP_CHECK_EN.
module retire_rename_table
    import rv32i_types::*;
#(
    parameter int FREE_Q_DEPTH = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   commit_valid,
    output logic                                   commit_ready,
    input  arch_idx_t                              commit_rd,
    input  preg_idx_t                              commit_pd,
    input  logic                                   branch_flush,
    output logic [NUM_ARCH_REGS*PREG_IDX_WIDTH-1:0] rat_restore,
    output preg_idx_t                              freed_preg,
    output logic                                   enqueue_freelist,
`ifdef RRF_DUP_CHECK_EN
    output logic                                   error_dup,
`endif
    input  logic                                   freelist_full
);

    rrf_commit_t commit;
    preg_idx_t   map_q [NUM_ARCH_REGS];
    preg_idx_t   map_d [NUM_ARCH_REGS];
    preg_idx_t   old_pd;
    logic        fire;
    logic        writes_rd;
    logic        push;
    logic        q_full;
    logic        q_empty;

    assign commit = {commit_rd, commit_pd};

    // No pop credit: readiness looks only at the registered queue state.
    assign commit_ready = !q_full;
    assign fire         = commit_valid && commit_ready;
    assign writes_rd    = fire && (commit.rd != '0);
    assign old_pd       = map_q[commit.rd];
    assign push         = writes_rd && (old_pd != commit.pd);

    assign enqueue_freelist = !q_empty && !freelist_full && !branch_flush;

    always_comb begin
        map_d = map_q;
        if (writes_rd) begin
            map_d[commit.rd] = commit.pd;
        end
    end

    // Restore view includes a commit firing this cycle (JAL/JALR under flush).
    for (genvar g = 0; g < NUM_ARCH_REGS; g++) begin : g_restore
        assign rat_restore[g*PREG_IDX_WIDTH +: PREG_IDX_WIDTH] = map_d[g];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ARCH_REGS; i++) begin
                map_q[i] <= identity_preg(i);
            end
        end else begin
            map_q <= map_d;
        end
    end

    free_preg_queue #(
        .DEPTH (FREE_Q_DEPTH)
    ) u_free_q (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (old_pd),
        .pop_i       (enqueue_freelist),
        .head_o      (freed_preg),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

`ifdef RRF_DUP_CHECK_EN
    logic [NUM_PREGS-1:0] live_q, live_d;
    logic                 error_dup_q;

    always_comb begin
        live_d = live_q;
        if (push) begin
            live_d[old_pd]    = 1'b0;
            live_d[commit.pd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            live_q      <= {{(NUM_PREGS-NUM_ARCH_REGS){1'b0}}, {NUM_ARCH_REGS{1'b1}}};
            error_dup_q <= 1'b0;
        end else begin
            live_q <= live_d;
            if (writes_rd && live_q[commit.pd]) begin
                error_dup_q <= 1'b1;
            end
        end
    end

    assign error_dup = error_dup_q;

    a_no_push_preg0 : assert property (@(posedge clk) disable iff (!rst) push |-> (old_pd != '0));
`endif

endmodule

// File: tb/tb_retire_rename_table.sv
// Bench for retire_rename_table: directed vector table plus randomized run
// against a queue/array reference model.
module tb_retire_rename_table;

    localparam int QD = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         commit_valid;
    logic         commit_ready;
    logic [4:0]   commit_rd;
    logic [5:0]   commit_pd;
    logic         branch_flush;
    logic [191:0] rat_restore;
    logic [5:0]   freed_preg;
    logic         enqueue_freelist;
    logic         freelist_full;
`ifdef RRF_DUP_CHECK_EN
    logic         error_dup;
`endif

    always #5 clk = ~clk;

    retire_rename_table #(.FREE_Q_DEPTH(QD)) dut (
        .clk              (clk),
        .rst              (rst),
        .commit_valid     (commit_valid),
        .commit_ready     (commit_ready),
        .commit_rd        (commit_rd),
        .commit_pd        (commit_pd),
        .branch_flush     (branch_flush),
        .rat_restore      (rat_restore),
        .freed_preg       (freed_preg),
        .enqueue_freelist (enqueue_freelist),
`ifdef RRF_DUP_CHECK_EN
        .error_dup        (error_dup),
`endif
        .freelist_full    (freelist_full)
    );

    int errors = 0;
    int checks = 0;

    // reference model
    int         mq[$];
    logic [5:0] mmap [32];
    logic       model_valid = 1'b0;
    logic       mdup = 1'b0;

    logic         act_ready, act_enq;
    logic [5:0]   act_freed;
    logic [191:0] act_restore;

    typedef struct {
        logic r, v;
        logic [4:0] rd;
        logic [5:0] pd;
        logic fl, fu;
        logic e_ready, e_enq;
        logic [5:0] e_freed;
        logic c_freed;
        logic [4:0] m_idx;
        logic [5:0] m_val;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, v, input int rd, pd, input logic fl, fu,
                                input logic er, ee, input int ef, input logic cf,
                                input int mi, mv);
        vec_t t;
        t.r = r; t.v = v; t.rd = 5'(rd); t.pd = 6'(pd); t.fl = fl; t.fu = fu;
        t.e_ready = er; t.e_enq = ee; t.e_freed = 6'(ef); t.c_freed = cf;
        t.m_idx = 5'(mi); t.m_val = 6'(mv);
        return t;
    endfunction

    task automatic cycle(input logic r, v, input logic [4:0] rd, input logic [5:0] pd,
                         input logic fl, fu);
        logic         e_ready, e_enq, fire, in_map;
        logic [191:0] e_rest;
        logic [5:0]   old;
        rst = r; commit_valid = v; commit_rd = rd; commit_pd = pd;
        branch_flush = fl; freelist_full = fu;
        @(negedge clk);
        e_ready = (mq.size() < QD);
        e_enq   = (mq.size() != 0) && !fu && !fl;
        fire    = v && e_ready;
        for (int i = 0; i < 32; i++) e_rest[i*6 +: 6] = mmap[i];
        if (fire && rd != 0) e_rest[int'(rd)*6 +: 6] = pd;
        act_ready = commit_ready; act_enq = enqueue_freelist;
        act_freed = freed_preg;   act_restore = rat_restore;
        if (model_valid) begin
            chk("model commit_ready", 192'(commit_ready), 192'(e_ready));
            chk("model enqueue_freelist", 192'(enqueue_freelist), 192'(e_enq));
            if (e_enq) chk("model freed_preg", 192'(freed_preg), 192'(mq[0]));
            chk("model rat_restore", rat_restore, e_rest);
`ifdef RRF_DUP_CHECK_EN
            chk("model error_dup", 192'(error_dup), 192'(mdup));
`endif
        end
        @(posedge clk);
        if (!r) begin
            mq.delete();
            for (int i = 0; i < 32; i++) mmap[i] = 6'(i);
            mdup = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (e_enq) void'(mq.pop_front());
            if (fire && rd != 0) begin
                in_map = 1'b0;
                for (int i = 0; i < 32; i++) if (mmap[i] == pd) in_map = 1'b1;
                if (in_map) mdup = 1'b1;
                old = mmap[rd];
                if (old != pd) mq.push_back(int'(old));
                mmap[rd] = pd;
            end
        end
        #1;
    endtask

    initial begin
        vec_t t;
        rst = 1'b0; commit_valid = 1'b0; commit_rd = '0; commit_pd = '0;
        branch_flush = 1'b0; freelist_full = 1'b0;

        //        r v rd pd  fl fu  rdy enq fr cf  idx val
        vecs.push_back(mk(1,0, 0, 0, 0,0, 1,0, 0,1,  0, 0));
        vecs.push_back(mk(1,1, 5,40, 0,0, 1,0, 0,0,  5,40));
        vecs.push_back(mk(1,1, 0,33, 0,0, 1,1, 5,0,  0, 0));
        vecs.push_back(mk(1,0, 0, 0, 0,0, 1,0, 0,0,  5,40));
        vecs.push_back(mk(1,1, 1,32, 0,1, 1,0, 0,0,  1,32));
        vecs.push_back(mk(1,1, 2,33, 0,1, 1,0, 0,0,  2,33));
        vecs.push_back(mk(1,1, 3,34, 0,1, 0,0, 0,0,  3, 3));
        vecs.push_back(mk(1,1, 3,34, 0,0, 0,1, 1,0,  3, 3));
        vecs.push_back(mk(1,1, 3,34, 0,0, 1,1, 2,0,  3,34));
        vecs.push_back(mk(1,0, 0, 0, 0,0, 1,1, 3,0,  3,34));
        vecs.push_back(mk(1,1, 7,50, 1,0, 1,0, 0,0,  7,50));
        vecs.push_back(mk(1,0, 0, 0, 0,0, 1,1, 7,0,  7,50));
        vecs.push_back(mk(1,1, 8,51, 0,0, 1,0, 0,0,  8,51));
        vecs.push_back(mk(1,0, 0, 0, 1,0, 1,0, 0,0,  8,51));
        vecs.push_back(mk(1,0, 0, 0, 0,0, 1,1, 8,0,  8,51));
        vecs.push_back(mk(1,1, 9, 9, 0,0, 1,0, 0,0,  9, 9));
        vecs.push_back(mk(1,0, 0, 0, 0,0, 1,0, 0,0,  9, 9));
        vecs.push_back(mk(1,1,10,52, 0,1, 1,0, 0,0, 10,52));
        vecs.push_back(mk(1,1,11,53, 0,1, 1,0, 0,0, 11,53));
        vecs.push_back(mk(0,1,12,54, 0,0, 0,1,10,0, 12,12));
        vecs.push_back(mk(1,0, 0, 0, 0,0, 1,0, 0,1, 10,10));

        cycle(1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);

        for (int k = 0; k < vecs.size(); k++) begin
            t = vecs[k];
            cycle(t.r, t.v, t.rd, t.pd, t.fl, t.fu);
            chk($sformatf("vec%0d commit_ready", k), 192'(act_ready), 192'(t.e_ready));
            chk($sformatf("vec%0d enqueue_freelist", k), 192'(act_enq), 192'(t.e_enq));
            if (t.e_enq || t.c_freed)
                chk($sformatf("vec%0d freed_preg", k), 192'(act_freed), 192'(t.e_freed));
            chk($sformatf("vec%0d rat_restore[%0d]", k, t.m_idx),
                192'(act_restore[int'(t.m_idx)*6 +: 6]), 192'(t.m_val));
        end

`ifdef RRF_DUP_CHECK_EN
        // rd=9 pd=9 straight after reset: no push, duplicate flag next cycle
        cycle(1'b0, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 5'd9, 6'd9, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
        chk("dup rd9 pd9 error_dup", 192'(error_dup), 192'(1'b1));
        chk("dup rd9 pd9 no enqueue", 192'(act_enq), 192'(1'b0));
`endif

        // JAL under flush with a pending entry: queue retained, commit still lands
        cycle(1'b1, 1'b1, 5'd4, 6'd44, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 5'd6, 6'd46, 1'b1, 1'b0);
        chk("flush jal restore[6]", 192'(act_restore[36 +: 6]), 192'(6'd46));
        chk("flush jal no drain", 192'(act_enq), 192'(1'b0));
        cycle(1'b1, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
        chk("post flush freed 4", 192'(act_freed), 192'(6'd4));
        cycle(1'b1, 1'b0, 5'd0, 6'd0, 1'b0, 1'b0);
        chk("post flush freed 6", 192'(act_freed), 192'(6'd6));

        for (int n = 0; n < 600; n++) begin
            logic       r, v, fl, fu;
            logic [4:0] rd;
            logic [5:0] pd;
            r  = ($urandom_range(99) != 0);
            v  = ($urandom_range(3) != 0);
            rd = 5'($urandom);
            pd = ($urandom_range(7) == 0) ? mmap[rd] : 6'($urandom);
            fl = ($urandom_range(4) == 0);
            fu = ($urandom_range(2) == 0);
            cycle(r, v, rd, pd, fl, fu);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
